// File: rtl/rf_sched_pkg.sv
// Shared types and widths for the weight RF address scheduler.
// Width constants here are the defaults for the scheduler's parameters.
package rf_sched_pkg;

    localparam int COORD_W = 7;
    localparam int S_W     = 3;
    localparam int LEN_W   = 11;
    localparam int CNT_W   = 17;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_HOLD,
        ST_DONE
    } sched_state_e;

    function automatic logic state_is_busy(input sched_state_e st);
        return st != ST_IDLE;
    endfunction

endpackage

// File: rtl/rf_addr_sched_pos_iter.sv
// Nested h/w/s position counter: s innermost, then w, then h.
// Sizes must be non-zero and stable while advancing.
module pos_iter #(
    parameter int COORD_W = 7,
    parameter int S_W     = 3
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_clear,
    input  logic               i_advance,
    input  logic [COORD_W-1:0] i_h_size,
    input  logic [COORD_W-1:0] i_w_size,
    input  logic [S_W-1:0]     i_s_size,
    output logic [COORD_W-1:0] o_h,
    output logic [COORD_W-1:0] o_w,
    output logic [S_W-1:0]     o_s,
    output logic               o_last
);

    logic [COORD_W-1:0] h_q, h_d;
    logic [COORD_W-1:0] w_q, w_d;
    logic [S_W-1:0]     s_q, s_d;
    logic               s_wrap, w_wrap, h_wrap;

    assign s_wrap = (s_q == i_s_size - S_W'(1));
    assign w_wrap = (w_q == i_w_size - COORD_W'(1));
    assign h_wrap = (h_q == i_h_size - COORD_W'(1));

    always_comb begin
        h_d = h_q;
        w_d = w_q;
        s_d = s_q;
        if (i_clear) begin
            h_d = '0;
            w_d = '0;
            s_d = '0;
        end else if (i_advance) begin
            if (s_wrap) begin
                s_d = '0;
                if (w_wrap) begin
                    w_d = '0;
                    h_d = h_q + COORD_W'(1);
                end else begin
                    w_d = w_q + COORD_W'(1);
                end
            end else begin
                s_d = s_q + S_W'(1);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            h_q <= '0;
            w_q <= '0;
            s_q <= '0;
        end else begin
            h_q <= h_d;
            w_q <= w_d;
            s_q <= s_d;
        end
    end

    assign o_h    = h_q;
    assign o_w    = w_q;
    assign o_s    = s_q;
    assign o_last = s_wrap && w_wrap && h_wrap;

endmodule

// File: rtl/rf_addr_sched.sv
// Job scheduler: one generator start per (h, w, s) position, then hands the
// finished RF batch downstream on valid/ready before advancing.
module rf_addr_sched #(
    parameter int COORD_W = rf_sched_pkg::COORD_W,
    parameter int S_W     = rf_sched_pkg::S_W,
    parameter int LEN_W   = rf_sched_pkg::LEN_W,
    parameter int CNT_W   = rf_sched_pkg::CNT_W
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_start,
    input  logic               i_abort,
    input  logic [COORD_W-1:0] i_h_size,
    input  logic [COORD_W-1:0] i_w_size,
    input  logic [S_W-1:0]     i_s_size,
    input  logic [LEN_W-1:0]   i_length,
    output logic               o_gen_start,
    output logic [COORD_W-1:0] o_gen_h,
    output logic [COORD_W-1:0] o_gen_w,
    output logic [S_W-1:0]     o_gen_s,
    output logic [LEN_W-1:0]   o_gen_length,
    input  logic               i_gen_finish,
    output logic               o_rf_valid,
    input  logic               i_rf_ready,
    output logic               o_busy,
    output logic               o_done,
    output logic [CNT_W-1:0]   o_batch_cnt
);

    import rf_sched_pkg::sched_state_e;
    import rf_sched_pkg::ST_IDLE;
    import rf_sched_pkg::ST_ISSUE;
    import rf_sched_pkg::ST_WAIT;
    import rf_sched_pkg::ST_HOLD;
    import rf_sched_pkg::ST_DONE;
    import rf_sched_pkg::state_is_busy;

    sched_state_e       state_q, state_d;
    logic [COORD_W-1:0] h_size_q, h_size_d;
    logic [COORD_W-1:0] w_size_q, w_size_d;
    logic [S_W-1:0]     s_size_q, s_size_d;
    logic [LEN_W-1:0]   length_q, length_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               gen_start_q, gen_start_d;
    logic               rf_valid_q, rf_valid_d;
    logic               done_q, done_d;
    logic               busy_q, busy_d;
    logic               pos_clear, pos_advance, pos_last;
    logic               empty_job;

    assign empty_job = (i_h_size == '0) || (i_w_size == '0) ||
                       (i_s_size == '0) || (i_length == '0);

    always_comb begin
        state_d     = state_q;
        h_size_d    = h_size_q;
        w_size_d    = w_size_q;
        s_size_d    = s_size_q;
        length_d    = length_q;
        cnt_d       = cnt_q;
        pos_clear   = 1'b0;
        pos_advance = 1'b0;
        // Abort overrides every other transition out of a busy state.
        if (i_abort && state_q != ST_IDLE) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (i_start) begin
                        h_size_d  = i_h_size;
                        w_size_d  = i_w_size;
                        s_size_d  = i_s_size;
                        length_d  = i_length;
                        cnt_d     = '0;
                        pos_clear = 1'b1;
                        state_d   = empty_job ? ST_DONE : ST_ISSUE;
                    end
                end
                ST_ISSUE: state_d = ST_WAIT;
                ST_WAIT: begin
                    if (i_gen_finish) state_d = ST_HOLD;
                end
                ST_HOLD: begin
                    if (i_rf_ready) begin
                        cnt_d = cnt_q + CNT_W'(1);
                        if (pos_last) begin
                            state_d = ST_DONE;
                        end else begin
                            pos_advance = 1'b1;
                            state_d     = ST_ISSUE;
                        end
                    end
                end
                ST_DONE: state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Status outputs are registered copies decoded from the next state.
    always_comb begin
        gen_start_d = (state_d == ST_ISSUE);
        rf_valid_d  = (state_d == ST_HOLD);
        done_d      = (state_d == ST_DONE);
        busy_d      = state_is_busy(state_d);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= ST_IDLE;
            h_size_q    <= '0;
            w_size_q    <= '0;
            s_size_q    <= '0;
            length_q    <= '0;
            cnt_q       <= '0;
            gen_start_q <= 1'b0;
            rf_valid_q  <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            h_size_q    <= h_size_d;
            w_size_q    <= w_size_d;
            s_size_q    <= s_size_d;
            length_q    <= length_d;
            cnt_q       <= cnt_d;
            gen_start_q <= gen_start_d;
            rf_valid_q  <= rf_valid_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
        end
    end

    pos_iter #(
        .COORD_W (COORD_W),
        .S_W     (S_W)
    ) u_pos_iter (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_clear   (pos_clear),
        .i_advance (pos_advance),
        .i_h_size  (h_size_q),
        .i_w_size  (w_size_q),
        .i_s_size  (s_size_q),
        .o_h       (o_gen_h),
        .o_w       (o_gen_w),
        .o_s       (o_gen_s),
        .o_last    (pos_last)
    );

    assign o_gen_start  = gen_start_q;
    assign o_rf_valid   = rf_valid_q;
    assign o_done       = done_q;
    assign o_busy       = busy_q;
    assign o_gen_length = length_q;
    assign o_batch_cnt  = cnt_q;

endmodule

// File: tb/tb_rf_addr_sched.sv
// Directed bench for rf_addr_sched: hand-computed cycle-by-cycle expectations.
module tb_rf_addr_sched;

    localparam int COORD_W = 7;
    localparam int S_W     = 3;
    localparam int LEN_W   = 11;
    localparam int CNT_W   = 17;

    logic               clk = 1'b0;
    logic               i_rst = 1'b1;
    logic               i_start = 1'b0;
    logic               i_abort = 1'b0;
    logic [COORD_W-1:0] i_h_size = '0;
    logic [COORD_W-1:0] i_w_size = '0;
    logic [S_W-1:0]     i_s_size = '0;
    logic [LEN_W-1:0]   i_length = '0;
    logic               i_gen_finish = 1'b0;
    logic               i_rf_ready = 1'b0;
    logic               o_gen_start;
    logic [COORD_W-1:0] o_gen_h;
    logic [COORD_W-1:0] o_gen_w;
    logic [S_W-1:0]     o_gen_s;
    logic [LEN_W-1:0]   o_gen_length;
    logic               o_rf_valid;
    logic               o_busy;
    logic               o_done;
    logic [CNT_W-1:0]   o_batch_cnt;

    int n_checks = 0;
    int n_errors = 0;
    int n_starts = 0;
    int n_done   = 0;

    always #5 clk = ~clk;

    rf_addr_sched dut (
        .i_clk        (clk),
        .i_rst        (i_rst),
        .i_start      (i_start),
        .i_abort      (i_abort),
        .i_h_size     (i_h_size),
        .i_w_size     (i_w_size),
        .i_s_size     (i_s_size),
        .i_length     (i_length),
        .o_gen_start  (o_gen_start),
        .o_gen_h      (o_gen_h),
        .o_gen_w      (o_gen_w),
        .o_gen_s      (o_gen_s),
        .o_gen_length (o_gen_length),
        .i_gen_finish (i_gen_finish),
        .o_rf_valid   (o_rf_valid),
        .i_rf_ready   (i_rf_ready),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_batch_cnt  (o_batch_cnt)
    );

    always @(negedge clk) begin
        if (o_gen_start) n_starts++;
        if (o_done) n_done++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_job(input int h, input int w, input int s, input int len);
        i_h_size = COORD_W'(h);
        i_w_size = COORD_W'(w);
        i_s_size = S_W'(s);
        i_length = LEN_W'(len);
        n_starts = 0;
        n_done   = 0;
        $display("job h=%0d w=%0d s=%0d len=%0d", h, w, s, len);
    endtask

    task automatic wait_start(input int bound);
        int n = 0;
        while (!o_gen_start && n < bound) begin
            tick();
            n++;
        end
        chk("start_seen", 32'(o_gen_start), 1);
    endtask

    task automatic chk_idle_zero(input string tag);
        chk({tag, "_busy"},  32'(o_busy), 0);
        chk({tag, "_valid"}, 32'(o_rf_valid), 0);
        chk({tag, "_start"}, 32'(o_gen_start), 0);
        chk({tag, "_done"},  32'(o_done), 0);
        chk({tag, "_cnt"},   32'(o_batch_cnt), 0);
        chk({tag, "_h"},     32'(o_gen_h), 0);
        chk({tag, "_w"},     32'(o_gen_w), 0);
        chk({tag, "_s"},     32'(o_gen_s), 0);
        chk({tag, "_len"},   32'(o_gen_length), 0);
    endtask

    int exp_h [4] = '{0, 0, 1, 1};
    int exp_s [4] = '{0, 1, 0, 1};
    int starts_before;

    initial begin
        tick();
        tick();
        i_rst = 1'b0;
        chk_idle_zero("reset");

        // Single-position job, finish pulsed at cycle 5.
        set_job(1, 1, 1, 4);
        i_rf_ready = 1'b1;
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        chk("t1_start_c1", 32'(o_gen_start), 1);
        chk("t1_h", 32'(o_gen_h), 0);
        chk("t1_w", 32'(o_gen_w), 0);
        chk("t1_s", 32'(o_gen_s), 0);
        chk("t1_len", 32'(o_gen_length), 4);
        chk("t1_busy", 32'(o_busy), 1);
        tick();
        chk("t1_start_c2", 32'(o_gen_start), 0);
        tick();
        tick();
        tick();
        i_gen_finish = 1'b1;
        chk("t1_valid_c5", 32'(o_rf_valid), 0);
        tick();
        i_gen_finish = 1'b0;
        chk("t1_valid_c6", 32'(o_rf_valid), 1);
        tick();
        chk("t1_done_c7", 32'(o_done), 1);
        chk("t1_cnt", 32'(o_batch_cnt), 1);
        chk("t1_nstarts", 32'(n_starts), 1);
        tick();
        chk("t1_busy_end", 32'(o_busy), 0);
        chk("t1_done_end", 32'(o_done), 0);

        // Multi-position job with a stray start during WAIT.
        set_job(2, 1, 2, 3);
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            wait_start(4);
            $display("batch k=%0d h=%0d w=%0d s=%0d", k, o_gen_h, o_gen_w, o_gen_s);
            chk("t2_h", 32'(o_gen_h), 32'(exp_h[k]));
            chk("t2_w", 32'(o_gen_w), 0);
            chk("t2_s", 32'(o_gen_s), 32'(exp_s[k]));
            chk("t2_len", 32'(o_gen_length), 3);
            tick();
            if (k == 1) i_start = 1'b1;
            tick();
            i_start = 1'b0;
            chk("t2_wait_nostart", 32'(o_gen_start), 0);
            i_gen_finish = 1'b1;
            tick();
            i_gen_finish = 1'b0;
            chk("t2_valid", 32'(o_rf_valid), 1);
            tick();
        end
        chk("t2_done", 32'(o_done), 1);
        chk("t2_cnt", 32'(o_batch_cnt), 4);
        tick();
        chk("t2_busy_end", 32'(o_busy), 0);
        chk("t2_nstarts", 32'(n_starts), 4);
        chk("t2_ndone", 32'(n_done), 1);

        // Backpressure: ready low for 3 HOLD cycles.
        set_job(1, 1, 2, 5);
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        tick();
        i_gen_finish = 1'b1;
        i_rf_ready = 1'b0;
        tick();
        i_gen_finish = 1'b0;
        starts_before = n_starts;
        for (int i = 0; i < 3; i++) begin
            chk("t3_valid_hold", 32'(o_rf_valid), 1);
            chk("t3_s_hold", 32'(o_gen_s), 0);
            chk("t3_nostart", 32'(o_gen_start), 0);
            tick();
        end
        chk("t3_valid_last", 32'(o_rf_valid), 1);
        chk("t3_cnt_hold", 32'(o_batch_cnt), 0);
        chk("t3_nstarts_hold", 32'(n_starts), 32'(starts_before));
        i_rf_ready = 1'b1;
        tick();
        chk("t3_adv_start", 32'(o_gen_start), 1);
        chk("t3_adv_s", 32'(o_gen_s), 1);
        chk("t3_adv_cnt", 32'(o_batch_cnt), 1);
        tick();
        i_gen_finish = 1'b1;
        tick();
        i_gen_finish = 1'b0;
        tick();
        chk("t3_done", 32'(o_done), 1);
        chk("t3_cnt", 32'(o_batch_cnt), 2);
        tick();

        // Empty jobs: zero filter columns, then zero length.
        set_job(2, 2, 0, 3);
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        chk("t5s_done", 32'(o_done), 1);
        chk("t5s_busy", 32'(o_busy), 1);
        chk("t5s_start", 32'(o_gen_start), 0);
        chk("t5s_cnt", 32'(o_batch_cnt), 0);
        tick();
        chk("t5s_busy_end", 32'(o_busy), 0);
        chk("t5s_nstarts", 32'(n_starts), 0);
        set_job(1, 1, 1, 0);
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        chk("t5l_done", 32'(o_done), 1);
        chk("t5l_start", 32'(o_gen_start), 0);
        tick();
        chk("t5l_busy_end", 32'(o_busy), 0);
        chk("t5l_nstarts", 32'(n_starts), 0);

        // Abort in WAIT, late finish must be ignored.
        set_job(2, 2, 2, 1);
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        tick();
        i_abort = 1'b1;
        tick();
        i_abort = 1'b0;
        chk("t4_busy", 32'(o_busy), 0);
        chk("t4_valid", 32'(o_rf_valid), 0);
        chk("t4_done", 32'(o_done), 0);
        chk("t4_start", 32'(o_gen_start), 0);
        tick();
        i_gen_finish = 1'b1;
        tick();
        i_gen_finish = 1'b0;
        chk("t4_late_valid", 32'(o_rf_valid), 0);
        chk("t4_late_busy", 32'(o_busy), 0);
        tick();
        chk("t4_ndone", 32'(n_done), 0);
        chk("t4_nstarts", 32'(n_starts), 1);

        // Reset while holding the second batch.
        set_job(1, 2, 1, 7);
        i_rf_ready = 1'b1;
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        tick();
        i_gen_finish = 1'b1;
        tick();
        i_gen_finish = 1'b0;
        tick();
        i_rf_ready = 1'b0;
        chk("t7_second_w", 32'(o_gen_w), 1);
        tick();
        i_gen_finish = 1'b1;
        tick();
        i_gen_finish = 1'b0;
        chk("t7_hold_valid", 32'(o_rf_valid), 1);
        chk("t7_hold_cnt", 32'(o_batch_cnt), 1);
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        chk_idle_zero("t7_rst");
        i_gen_finish = 1'b1;
        tick();
        i_gen_finish = 1'b0;
        chk("t7_late_valid", 32'(o_rf_valid), 0);
        chk("t7_late_busy", 32'(o_busy), 0);
        tick();
        chk("t7_late_done", 32'(o_done), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/rf_addr_sched.md
# rf_addr_sched

Job-level scheduler for the weight register-file address generator in the sparse convolution datapath. It walks every activation position (h, w) and filter column s of a layer tile and issues one generator start per position. It waits for the generator's finish, then offers the completed RF batch downstream on a valid/ready handshake before moving on. It sits between the layer controller, which configures the tile, and the address generator / PE-array loader.

## Interface
Parameters:
- `COORD_W`, 7: h/w coordinate width.
- `S_W`, 3: filter-column coordinate width.
- `LEN_W`, 11: weight-list length width.
- `CNT_W`, 17: completed-batch counter width; 127·127·7 < 2^17.

Ports:
- `i_clk`  in  1  clock, single domain.
- `i_rst`  in  1  reset, synchronous, active-high.
- `i_start`  in  1  job start, sampled only in IDLE.
- `i_abort`  in  1  synchronous flush, effective in any state.
- `i_h_size`  in  COORD_W  rows in tile.
- `i_w_size`  in  COORD_W  columns in tile.
- `i_s_size`  in  S_W  filter columns.
- `i_length`  in  LEN_W  compressed weight count per batch.
- `o_gen_start`  out  1  one-cycle start pulse to the generator.
- `o_gen_h`  out  COORD_W  current h.
- `o_gen_w`  out  COORD_W  current w.
- `o_gen_s`  out  S_W  current s.
- `o_gen_length`  out  LEN_W  latched length.
- `i_gen_finish`  in  1  generator finish pulse.
- `o_rf_valid`  out  1  RF batch ready for consumer.
- `i_rf_ready`  in  1  consumer accepts the batch.
- `o_busy`  out  1  high in every state except IDLE.
- `o_done`  out  1  one-cycle pulse at job completion.
- `o_batch_cnt`  out  CNT_W  batches accepted in the current job.

## Operation
- States: IDLE, ISSUE, WAIT, HOLD, DONE.
- IDLE:
  - On `i_start`, latch the sizes and length, clear the coordinates and `o_batch_cnt`.
  - If any size is 0 or `i_length`==0, go to DONE. Otherwise go to ISSUE.
- ISSUE:
  - `o_gen_start`=1 for exactly this cycle; coordinates are valid.
  - Always go to WAIT.
- WAIT:
  - Go to HOLD on the cycle `i_gen_finish`=1; otherwise stay.
- HOLD:
  - `o_rf_valid`=1, and the coordinates are held stable.
  - On `i_rf_ready`, `o_batch_cnt`++.
  - If the position is the last one (h=H−1, w=W−1, s=S−1), go to DONE. Otherwise advance the position and go to ISSUE.
- DONE: `o_done`=1 for one cycle, then IDLE. `o_batch_cnt` holds until the next start.
- Iteration order: s innermost, then w, then h. Each coordinate wraps to 0 when the next-outer one increments.
- `i_gen_finish` outside WAIT is ignored.
- `i_start` while busy is ignored.
- `i_abort` in any non-IDLE state:
  - Next state is IDLE.
  - No `o_gen_start`, `o_rf_valid` or `o_done` in the abort cycle's successor.
  - Abort has priority over every other transition.
- Reset values: state IDLE; all outputs 0, including coordinates, `o_gen_length` and `o_batch_cnt`.
- Reset mid-job: same as the reset values; a later `i_gen_finish` is ignored.

## Timing
- `i_start` at cycle 0 → ISSUE at cycle 1 (`o_gen_start`=1) → WAIT from cycle 2.
- `i_gen_finish` at cycle N → `o_rf_valid` at N+1.
- If `i_rf_ready`=1 at N+1, then at N+2 either the next ISSUE or DONE.
- Minimum per-batch overhead beyond the generator latency: 3 cycles (ISSUE, HOLD, plus the WAIT sampling cycle).
- All outputs are registered or decoded from state only; no combinational path from any input to any output.
- Zero-size job: `i_start` at 0 → `o_done` at 1, `o_busy` at 1, IDLE at 2.

## Structure
- Package `rf_sched_pkg` holds:
  - the state enum `sched_state_e`;
  - the width constants `COORD_W`, `S_W`, `LEN_W`, `CNT_W`.
- The header macros for `IA_CHANNEL` and `W_C_LENGTH` remain the source for datapath sizing.
- Sub-module `pos_iter` is the nested h/w/s counter.
  - Inputs: clear, advance, latched sizes.
  - Outputs: coordinates, `last`.
  - Instantiated once.

## Test plan
- Sizes h=1, w=1, s=1, len=4; ready tied 1; bench pulses finish at cycle 5.
  - → `o_gen_start` only at cycle 1 with (0,0,0).
  - → `o_rf_valid` at 6, `o_done` at 7, `o_batch_cnt`=1.
- h=2, w=1, s=2, len=3.
  - → starts in order (0,0,0), (0,0,1), (1,0,0), (1,0,1).
  - → exactly 4 `o_gen_start` pulses, final `o_batch_cnt`=4, one `o_done`.
- Backpressure: ready held low 3 cycles in HOLD.
  - → `o_rf_valid` stays 1 with coordinates stable.
  - → no `o_gen_start`; advance on the cycle after ready rises.
- `i_abort` in WAIT, then finish pulsed 2 cycles later.
  - → IDLE next cycle, `o_busy`=0, no `o_rf_valid`, no `o_done`.
- `i_s_size`=0, or `i_length`=0 → `o_done` at cycle 1, zero `o_gen_start`, `o_batch_cnt`=0.
- `i_start` pulsed during WAIT → ignored (no extra start).
- `i_rst` asserted in HOLD → next cycle all outputs 0 and state IDLE.
